// File: rtl/gpio_multi_pkg.sv
// gpio_multi shared definitions: register-map word indices, byte-lane
// offsets, bus FSM state encodings and read-word layouts.
package gpio_multi_pkg;

  localparam int unsigned IDX_W     = 5;
  localparam logic [4:0]  IRQ_WORD  = 5'h10;

  localparam int unsigned LANE_PIN  = 0;
  localparam int unsigned LANE_DDR  = 1;
  localparam int unsigned LANE_PORT = 2;
  localparam int unsigned LANE_MSK  = 3;

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACK    = 2'd1;
  localparam logic [1:0]  ST_HOLD   = 2'd2;

  // Layout of a port word as seen on the bus
  typedef struct packed {
    logic [7:0] pcmsk;
    logic [7:0] port;
    logic [7:0] ddr;
    logic [7:0] pin;
  } port_word_t;

  // Layout of the interrupt flag/enable word
  typedef struct packed {
    logic [15:0] pcie;
    logic [15:0] pcif;
  } irq_word_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchroniser plus previous-sample register for one port;
// chg flags bits whose synchronised value differs from the last cycle.
module gpio_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] chg
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign chg  = sync_q ^ prev_q;

endmodule

// File: rtl/gpio_multi.sv
// Parametrised multi-port GPIO with pin-change interrupts.
// Optional build macro GPIO_PIN_TOGGLE_EN: writing 1 to a PIN bit toggles
// the matching PORT bit; otherwise PIN is read-only.
module gpio_multi
  import gpio_multi_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned PORT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mem_valid,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_wdata,
  input  logic [3:0]                      mem_wstrb,
  output logic [31:0]                     mem_rdata,
  output logic                            mem_ready,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_pin_dir,
  output logic [NUM_PORTS-1:0]            irq
);

  logic [1:0]            state_q, state_d;
  logic                  ready_d;
  logic [31:0]           rdata_d;
  logic [31:0]           rd_word;
  logic                  accept;
  logic                  wr_en;
  logic [IDX_W-1:0]      idx;

  logic [PORT_WIDTH-1:0] ddr_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] port_q  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] pcmsk_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] sync_w  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] chg_w   [NUM_PORTS];

  logic [NUM_PORTS-1:0]  pcif_q, pcie_q, pcie_nx, pcif_clr, pc_set;
  logic                  unused_addr;

  assign idx         = mem_addr[6:2];
  assign unused_addr = ^{mem_addr[31:7], mem_addr[1:0]};
  assign accept      = (state_q == ST_IDLE) && mem_valid;
  assign wr_en       = accept && (|mem_wstrb);

  // Per-port synchroniser, change detect and PCMSK/DDR/PORT registers
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [PORT_WIDTH-1:0] port_nx;

    gpio_sync_edge #(.WIDTH(PORT_WIDTH)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (gpio_pin_in[p*PORT_WIDTH +: PORT_WIDTH]),
      .sync (sync_w[p]),
      .chg  (chg_w[p])
    );

    assign pc_set[p] = |(chg_w[p] & pcmsk_q[p]);
    assign gpio_pin_out[p*PORT_WIDTH +: PORT_WIDTH] = port_q[p];
    assign gpio_pin_dir[p*PORT_WIDTH +: PORT_WIDTH] = ddr_q[p];

    // PORT lane write lands first, then any PIN-lane toggle on top of it
    always_comb begin
      port_nx = port_q[p];
      if (mem_wstrb[LANE_PORT])
        port_nx = PORT_WIDTH'(mem_wdata[LANE_PORT*8 +: 8]);
`ifdef GPIO_PIN_TOGGLE_EN
      if (mem_wstrb[LANE_PIN])
        port_nx = port_nx ^ PORT_WIDTH'(mem_wdata[LANE_PIN*8 +: 8]);
`endif
    end

    // Byte-lane register writes for this port
    always_ff @(posedge clk) begin
      if (rst) begin
        ddr_q[p]   <= '0;
        port_q[p]  <= '0;
        pcmsk_q[p] <= '0;
      end else if (wr_en && (idx == IDX_W'(p))) begin
        if (mem_wstrb[LANE_DDR]) ddr_q[p]   <= PORT_WIDTH'(mem_wdata[LANE_DDR*8 +: 8]);
        if (mem_wstrb[LANE_MSK]) pcmsk_q[p] <= PORT_WIDTH'(mem_wdata[LANE_MSK*8 +: 8]);
        port_q[p] <= port_nx;
      end
    end
  end

  // Interrupt-word write decode: PCIE lanes and PCIF write-1-to-clear mask
  always_comb begin
    pcie_nx  = pcie_q;
    pcif_clr = '0;
    if (wr_en && (idx == IRQ_WORD)) begin
      for (int b = 0; b < NUM_PORTS; b++) begin
        if (mem_wstrb[2 + b/8]) pcie_nx[b] = mem_wdata[16 + b];
        if (mem_wstrb[b/8] && mem_wdata[b]) pcif_clr[b] = 1'b1;
      end
    end
  end

  // Flag/enable registers; a new change wins over a same-edge clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pcif_q <= '0;
      pcie_q <= '0;
    end else begin
      pcif_q <= (pcif_q & ~pcif_clr) | pc_set;
      pcie_q <= pcie_nx;
    end
  end

  assign irq = pcif_q & pcie_q;

  // Read mux over the register map; unmapped words read zero
  always_comb begin
    port_word_t pw;
    irq_word_t  iw;
    rd_word = '0;
    pw      = '0;
    iw      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx == IDX_W'(p)) begin
        pw.pin   = 8'(sync_w[p]);
        pw.ddr   = 8'(ddr_q[p]);
        pw.port  = 8'(port_q[p]);
        pw.pcmsk = 8'(pcmsk_q[p]);
        rd_word  = pw;
      end
    end
    if (idx == IRQ_WORD) begin
      iw.pcif = 16'(pcif_q);
      iw.pcie = 16'(pcie_q);
      rd_word = iw;
    end
  end

  // Bus FSM next state and registered ready/rdata
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_valid)  state_d = ST_ACK;
      ST_ACK:                  state_d = ST_HOLD;
      ST_HOLD: if (!mem_valid) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_ACK);
    rdata_d = accept ? rd_word : 32'd0;
  end

  // Bus FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      mem_ready <= ready_d;
      mem_rdata <= rdata_d;
    end
  end

endmodule
